// File: rtl/done_sequencer.sv
// Reset-to-done handshake initiator/checker: holds a downstream producer in reset, releases it,
// times its done response and reports pass/fail with the measured latency. Optional pass/fail counters under DONE_SEQ_STATS_EN.
module done_sequencer #(
    parameter int RST_CYCLES = 2,
    parameter int MIN_LAT    = 1,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             dut_done,
    output logic             dut_rst,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] latency
`ifdef DONE_SEQ_STATS_EN
    ,
    output logic [15:0]      pass_cnt,
    output logic [15:0]      fail_cnt
`endif
);

    localparam int MAX_CNT = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_VAL  = CNT_W'(MIN_LAT);

    generate
        if (MAX_CNT < TIMEOUT || MAX_CNT < RST_CYCLES || RST_CYCLES < 1 ||
            TIMEOUT < 1 || MIN_LAT < 0 || TIMEOUT < MIN_LAT) begin : g_param_check
            $error("done_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RESET, WAIT, REPORT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             rst_q, rst_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        rst_d   = rst_q;
        busy_d  = busy_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE: begin
                rst_d  = 1'b1;
                busy_d = 1'b0;
                if (go) begin
                    state_d = RESET;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    rst_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                // Every exit re-asserts the producer reset and drops busy together with the pulse.
                if (dut_done) begin
                    state_d = REPORT;
                    rst_d   = 1'b1;
                    busy_d  = 1'b0;
                    lat_d   = cnt_q;
                    if (cnt_q >= MIN_VAL) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = REPORT;
                    rst_d   = 1'b1;
                    busy_d  = 1'b0;
                    lat_d   = TO_VAL;
                    fail_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            rst_q   <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            rst_q   <= rst_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign dut_rst = rst_q;
    assign busy    = busy_q;
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign latency = lat_q;

`ifdef DONE_SEQ_STATS_EN
    logic [15:0] pass_cnt_q, fail_cnt_q;

    // Counters step on the same edge that launches their pulse and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            if (pass_d && pass_cnt_q != 16'hFFFF) begin
                pass_cnt_q <= pass_cnt_q + 16'd1;
            end
            if (fail_d && fail_cnt_q != 16'hFFFF) begin
                fail_cnt_q <= fail_cnt_q + 16'd1;
            end
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_done_sequencer.sv
// Self-checking bench for done_sequencer: scoreboarded runs against a modelled done-producer,
// plus a MIN_LAT=4 instance for the early-done case. Checks the counters when DONE_SEQ_STATS_EN is defined.
module tb_done_sequencer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       go    = 1'b0;
    logic       goE   = 1'b0;
    logic [1:0] doneMode = 2'd0;
    logic       dutDone;
    logic       doneHigh = 1'b1;

    logic       dutRst, busy, pass, fail;
    logic [7:0] latency;
    logic       eRst, eBusy, ePass, eFail;
    logic [7:0] eLat;
`ifdef DONE_SEQ_STATS_EN
    logic [15:0] passCnt, failCnt, ePassCnt, eFailCnt;
`endif

    typedef struct {
        logic       expPass;
        logic       expFail;
        logic [7:0] expLat;
        int         expCycles;
        int         goCycle;
    } expItem_t;

    expItem_t sbQueue[$];
    int vectors     = 0;
    int miscompares = 0;
    int cycleCnt    = 0;

    logic [3:0] prodCnt;
    logic       prodDone;
    logic [3:0] numClk = 4'd2;

    done_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .dut_done (dutDone),
        .dut_rst  (dutRst),
        .busy     (busy),
        .pass     (pass),
        .fail     (fail),
        .latency  (latency)
`ifdef DONE_SEQ_STATS_EN
        ,
        .pass_cnt (passCnt),
        .fail_cnt (failCnt)
`endif
    );

    done_sequencer #(.MIN_LAT(4)) dutEarly (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (goE),
        .dut_done (doneHigh),
        .dut_rst  (eRst),
        .busy     (eBusy),
        .pass     (ePass),
        .fail     (eFail),
        .latency  (eLat)
`ifdef DONE_SEQ_STATS_EN
        ,
        .pass_cnt (ePassCnt),
        .fail_cnt (eFailCnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Producer model: raises done numClk+1 edges after its reset is released.
    always @(posedge clk) begin
        if (dutRst) begin
            prodCnt  <= 4'd0;
            prodDone <= 1'b0;
        end else if (prodCnt == numClk) begin
            prodDone <= 1'b1;
        end else begin
            prodCnt <= prodCnt + 4'd1;
        end
    end

    assign dutDone = (doneMode == 2'd0) ? prodDone : (doneMode == 2'd2);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit pushExp, input logic ePassV, input logic eFailV,
                                 input logic [7:0] eLatV, input int eCycles);
        expItem_t item;
        @(negedge clk);
        if (pushExp) begin
            item.expPass   = ePassV;
            item.expFail   = eFailV;
            item.expLat    = eLatV;
            item.expCycles = eCycles;
            item.goCycle   = cycleCnt;
            sbQueue.push_back(item);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitReport(input string tag);
        int waited = 0;
        expItem_t item;
        while (!(pass === 1'b1 || fail === 1'b1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checkOutput({tag, "_pulse"}, {31'd0, pass | fail}, 32'd1);
            if (sbQueue.size() > 0) void'(sbQueue.pop_front());
            return;
        end
        if (sbQueue.size() == 0) begin
            checkOutput({tag, "_sbEmpty"}, sbQueue.size(), 32'd1);
            return;
        end
        item = sbQueue.pop_front();
        checkOutput({tag, "_pass"},    {31'd0, pass},    {31'd0, item.expPass});
        checkOutput({tag, "_fail"},    {31'd0, fail},    {31'd0, item.expFail});
        checkOutput({tag, "_latency"}, {24'd0, latency}, {24'd0, item.expLat});
        checkOutput({tag, "_cycles"},  cycleCnt - item.goCycle, item.expCycles);
        checkOutput({tag, "_rptState"}, {30'd0, busy, dutRst}, 32'b01);
        @(negedge clk);
        checkOutput({tag, "_oneShot"}, {29'd0, pass, fail, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting done_sequencer bench");
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstOutputs", {28'd0, dutRst, busy, pass, fail}, 32'b1000);
        checkOutput("rstLatency", {24'd0, latency}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idleHold", {28'd0, busy, dutRst, pass, fail}, 32'b0100);
        end

        // Nominal run: reset held two cycles, producer answers with latency 3.
        doneMode = 2'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 7);
        checkOutput("nomRst1", {30'd0, busy, dutRst}, 32'b11);
        @(negedge clk);
        checkOutput("nomRst2", {30'd0, busy, dutRst}, 32'b11);
        @(negedge clk);
        checkOutput("nomRelease", {30'd0, busy, dutRst}, 32'b10);
        waitReport("nominal");

        // Timeout: done never rises, fail after 16 WAIT cycles.
        doneMode = 2'd1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd16, 19);
        waitReport("timeout");

        // Early done on the MIN_LAT=4 instance with done tied high.
        @(negedge clk);
        goE = 1'b1;
        @(negedge clk);
        goE = 1'b0;
        checkOutput("earlyRst1", {29'd0, eBusy, eRst, eFail}, 32'b110);
        @(negedge clk);
        checkOutput("earlyRst2", {29'd0, eBusy, eRst, eFail}, 32'b110);
        @(negedge clk);
        checkOutput("earlyWait", {29'd0, eBusy, eRst, eFail}, 32'b100);
        @(negedge clk);
        checkOutput("earlyReport", {28'd0, ePass, eFail, eBusy, eRst}, 32'b0101);
        checkOutput("earlyLatency", {24'd0, eLat}, 32'd0);
        @(negedge clk);
        checkOutput("earlyOneShot", {30'd0, ePass, eFail}, 32'd0);

        // Abort: go ignored in WAIT, then async reset mid-run.
        doneMode = 2'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 0);
        @(negedge clk);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checkOutput("goIgnored", {30'd0, busy, dutRst}, 32'b10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortAsync", {28'd0, dutRst, busy, pass, fail}, 32'b1000);
        checkOutput("abortLatency", {24'd0, latency}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("abortQuiet", {29'd0, pass, fail, busy}, 32'd0);
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 7);
        waitReport("cleanRun");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 7);
        waitReport("nominal2");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd3, 7);
        waitReport("nominal3");
        doneMode = 2'd1;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd16, 19);
        waitReport("timeout2");
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd16, 19);
        waitReport("timeout3");

`ifdef DONE_SEQ_STATS_EN
        checkOutput("passCnt", {16'd0, passCnt}, 32'd3);
        checkOutput("failCnt", {16'd0, failCnt}, 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("passCntClr", {16'd0, passCnt}, 32'd0);
        checkOutput("failCntClr", {16'd0, failCnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        checkOutput("sbDrained", sbQueue.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
